// File: rtl/display_scan_driver_pkg.sv
// display_scan_driver_pkg
// Shared constants and types for the multiplexed 4-digit 7-segment scan driver:
//   - digit index constants (tens, ones, tenths, hundredths)
//   - special digit codes (dash, 'E')
//   - active-low segment patterns, ordered {g,f,e,d,c,b,a}
//   - scan FSM state type
package display_scan_driver_pkg;

  localparam logic [1:0] IDX_TENS       = 2'd0;
  localparam logic [1:0] IDX_ONES       = 2'd1;
  localparam logic [1:0] IDX_TENTHS     = 2'd2;
  localparam logic [1:0] IDX_HUNDREDTHS = 2'd3;

  localparam logic [4:0] CODE_DASH = 5'd10;
  localparam logic [4:0] CODE_E    = 5'd14;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] ANODE_OFF = 4'b1111;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/display_scan_driver_seg7_decode.sv
// seg7_decode
// Combinational digit-code to 7-segment decoder.
//   code : 5-bit digit code (0-9 digits, 10 dash, 14 'E', others blank)
//   seg  : 7-bit active-low segments {g,f,e,d,c,b,a}
module seg7_decode
  import display_scan_driver_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      5'd0:      seg = SEG_0;
      5'd1:      seg = SEG_1;
      5'd2:      seg = SEG_2;
      5'd3:      seg = SEG_3;
      5'd4:      seg = SEG_4;
      5'd5:      seg = SEG_5;
      5'd6:      seg = SEG_6;
      5'd7:      seg = SEG_7;
      5'd8:      seg = SEG_8;
      5'd9:      seg = SEG_9;
      CODE_DASH: seg = SEG_DASH;
      CODE_E:    seg = SEG_E;
      default:   seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_driver.sv
// display_scan_driver
// Time-multiplexed scan driver for a 4-digit common-anode 7-segment display.
// Each digit gets BLANK_CYCLES clocks with all anodes off (ghosting guard and
// settling time for the external digit mux), then SHOW_CYCLES clocks lit.
//
// Parameters:
//   SHOW_CYCLES   clocks each digit is lit (>= 1)
//   BLANK_CYCLES  clocks all anodes are off before each digit (>= 1)
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-high reset (priority over display_En)
//   display_En     high scans, low forces blank and holds select_State
//   current_Select digit code from the external mux for select_State
//   select_State   registered digit index to the mux (0 tens .. 3 hundredths)
//   seg            registered active-low segments {g,f,e,d,c,b,a}
//   anode          registered active-low digit enables, anode[i] = digit i
//   dp             registered active-low decimal point (lit on index 1)
//   frame_Tick     one-clock pulse when the scan wraps from index 3 to 0
// Configuration macro:
//   LEADING_ZERO_BLANK_EN  when defined, code 0 on the tens digit is blanked
module display_scan_driver
  import display_scan_driver_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       display_En,
  input  logic [4:0] current_Select,
  output logic [1:0] select_State,
  output logic [6:0] seg,
  output logic [3:0] anode,
  output logic       dp,
  output logic       frame_Tick
);

  localparam int unsigned MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int unsigned CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  scan_state_t   state;
  logic [CW-1:0] phase;
  logic [6:0]    dec_seg;
  logic [6:0]    show_seg;

  seg7_decode u_decode (
    .code (current_Select),
    .seg  (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    show_seg = dec_seg;
    if (select_State == IDX_TENS && current_Select == 5'd0)
      show_seg = SEG_BLANK;
  end
`else
  always_comb begin
    show_seg = dec_seg;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_BLANK;
      phase        <= '0;
      select_State <= IDX_TENS;
      anode        <= ANODE_OFF;
      seg          <= SEG_BLANK;
      dp           <= 1'b1;
      frame_Tick   <= 1'b0;
    end else if (!display_En) begin
      // select_State is deliberately left untouched so scanning resumes
      // on the same digit after a full blank interval.
      state      <= ST_BLANK;
      phase      <= '0;
      anode      <= ANODE_OFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_Tick <= 1'b0;
    end else begin
      frame_Tick <= 1'b0;
      case (state)
        ST_BLANK: begin
          if (phase == BLANK_LAST) begin
            state <= ST_SHOW;
            phase <= '0;
            seg   <= show_seg;
            anode <= ~(4'b0001 << select_State);
            dp    <= (select_State != IDX_ONES);
          end else begin
            phase <= phase + 1'b1;
          end
        end
        ST_SHOW: begin
          if (phase == SHOW_LAST) begin
            state        <= ST_BLANK;
            phase        <= '0;
            select_State <= select_State + 2'd1;
            anode        <= ANODE_OFF;
            seg          <= SEG_BLANK;
            dp           <= 1'b1;
            frame_Tick   <= (select_State == IDX_HUNDREDTHS);
          end else begin
            phase <= phase + 1'b1;
          end
        end
        default: begin
          state <= ST_BLANK;
          phase <= '0;
        end
      endcase
    end
  end

endmodule
